// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port front end for the single-port data_mem.
//   Port 0 (pipeline MEM stage) has fixed priority. Port 1 (loader/debug) is
//   protected by a starvation counter that forces it through after
//   STARVE_LIMIT consecutive denied cycles.
//   The winning command is registered for one cycle toward data_mem. A two-stage
//   {valid,port} tag pipe steers the registered read data back to its owner
//   two cycles after the grant.
// Build option: define DMEM_ARB_RR_EN to replace the priority/starvation scheme
//   with two-way round-robin. A 1-bit last-winner pointer decides ties.
module dmem_arbiter #(
  parameter int DW           = 32,
  parameter int AW           = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  // port 0: pipeline MEM stage
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  // port 1: loader / debug master
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  // data_mem side
  output logic          mem_r,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic win0;
  logic win1;

`ifdef DMEM_ARB_RR_EN
  // last_winner_reg = 1 means port 1 took the most recent grant
  logic last_winner_reg;

  // Round-robin pick: on a tie the port that did not win last goes first
  always_comb begin
    win0 = 1'b0;
    win1 = 1'b0;
    if (m0_req && m1_req) begin
      win0 = last_winner_reg;
      win1 = ~last_winner_reg;
    end else begin
      win0 = m0_req;
      win1 = m1_req;
    end
  end

  // Pointer moves only when somebody is actually granted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_winner_reg <= 1'b1;
    end else if (win0 || win1) begin
      last_winner_reg <= win1;
    end
  end
`else
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;

  // Fixed priority to port 0 unless port 1 has been starved long enough
  always_comb begin
    win1 = m1_req && (!m0_req || (starve_cnt_reg == LIMIT));
    win0 = m0_req && !win1;
  end

  // Count denied port-1 cycles, saturating; any grant or withdrawal clears it
  always_comb begin
    starve_cnt_next = starve_cnt_reg;
    if (!m1_req || win1) begin
      starve_cnt_next = '0;
    end else if (starve_cnt_reg != LIMIT) begin
      starve_cnt_next = starve_cnt_reg + 1'b1;
    end
  end

  // Starvation counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end
`endif

  // Grants are combinational but forced low while reset is asserted
  assign m0_gnt = win0 && rst_n;
  assign m1_gnt = win1 && rst_n;

  logic          mem_r_reg;
  logic          mem_w_reg;
  logic [AW-1:0] mem_addr_reg;
  logic [DW-1:0] mem_wdata_reg;

  // Command register: strobes last one cycle, address/data hold while idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_r_reg     <= 1'b0;
      mem_w_reg     <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
    end else begin
      mem_r_reg <= (win0 && !m0_we) || (win1 && !m1_we);
      mem_w_reg <= (win0 && m0_we) || (win1 && m1_we);
      if (win1) begin
        mem_addr_reg  <= m1_addr;
        mem_wdata_reg <= m1_wdata;
      end else if (win0) begin
        mem_addr_reg  <= m0_addr;
        mem_wdata_reg <= m0_wdata;
      end
    end
  end

  assign mem_r     = mem_r_reg;
  assign mem_w     = mem_w_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;

  // Stage 1 aligns with the command cycle, stage 2 with data_mem's output cycle
  logic tag1_valid_reg;
  logic tag1_port_reg;
  logic tag2_valid_reg;
  logic tag2_port_reg;

  // Read tag pipe: only reads enter, writes never produce a return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag1_valid_reg <= 1'b0;
      tag1_port_reg  <= 1'b0;
      tag2_valid_reg <= 1'b0;
      tag2_port_reg  <= 1'b0;
    end else begin
      tag1_valid_reg <= (win0 && !m0_we) || (win1 && !m1_we);
      tag1_port_reg  <= win1;
      tag2_valid_reg <= tag1_valid_reg;
      tag2_port_reg  <= tag1_port_reg;
    end
  end

  // Return steering: the valid pulse goes to the owner, data is shared passthrough
  assign m0_rvalid = tag2_valid_reg && !tag2_port_reg;
  assign m1_rvalid = tag2_valid_reg && tag2_port_reg;
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter with a behavioural data_mem and a read scoreboard.
// Honours DMEM_ARB_RR_EN so the same bench covers both arbitration builds.
module tb_dmem_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;
  localparam int LIM = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m0_req = 1'b0, m0_we = 1'b0;
  logic [AW-1:0] m0_addr = '0;
  logic [DW-1:0] m0_wdata = '0;
  logic          m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m1_addr = '0;
  logic [DW-1:0] m1_wdata = '0;
  logic          m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          mem_r, mem_w;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  dmem_arbiter #(.DW(DW), .AW(AW), .STARVE_LIMIT(LIM), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_r(mem_r), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // Behavioural data_mem: single port, registered read
  logic [DW-1:0] dmem [0:255];
  always @(posedge clk) begin
    if (mem_w) dmem[mem_addr[7:0]] <= mem_wdata;
    if (mem_r) mem_rdata <= dmem[mem_addr[7:0]];
  end

  int checks_cnt = 0;
  int errors_cnt = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks_cnt++;
    if (act !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cycle);
    end
  endtask

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
    int            cyc;
  } rd_t;
  rd_t sb[$];

  // Reference state, owned by the monitor
  logic [DW-1:0] ref_mem [0:255];
  int            m_cnt = 0;
  logic          m_last = 1'b1;
  logic          x0, x1;
  logic          e_r = 1'b0, e_w = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_wdata = '0;

  // Monitor: checks command issue, read returns and grants every cycle
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_cnt = 0;
      m_last = 1'b1;
      e_r = 1'b0; e_w = 1'b0; e_addr = '0; e_wdata = '0;
    end else begin
      check("mem_r", mem_r, e_r);
      check("mem_w", mem_w, e_w);
      check("mem_addr", mem_addr, e_addr);
      check("mem_wdata", mem_wdata, e_wdata);
      if (m0_rvalid || m1_rvalid) begin
        if (sb.size() == 0) begin
          check("rvalid_unexpected", {m0_rvalid, m1_rvalid}, 2'b00);
        end else begin
          rd_t e;
          e = sb.pop_front();
          $display("ret port%0d data 0x%08h cycle %0d", e.port, e.port ? m1_rdata : m0_rdata, cycle);
          check("rvalid_port", {m0_rvalid, m1_rvalid}, e.port ? 2'b01 : 2'b10);
          check("rdata", e.port ? m1_rdata : m0_rdata, e.data);
          check("rd_latency", cycle, e.cyc);
        end
      end else if (sb.size() > 0 && sb[0].cyc <= cycle) begin
        check("rvalid_missing", 1'b0, 1'b1);
        void'(sb.pop_front());
      end
`ifdef DMEM_ARB_RR_EN
      if (m0_req && m1_req) begin x1 = !m_last; x0 = m_last; end
      else begin x0 = m0_req; x1 = m1_req; end
      if (x0 || x1) m_last = x1;
`else
      x1 = m1_req && (!m0_req || m_cnt == LIM);
      x0 = m0_req && !x1;
      if (!m1_req || x1) m_cnt = 0;
      else if (m_cnt < LIM) m_cnt++;
`endif
      check("gnt", {m0_gnt, m1_gnt}, {x0, x1});
      e_r = (x0 && !m0_we) || (x1 && !m1_we);
      e_w = (x0 && m0_we) || (x1 && m1_we);
      if (x1) begin e_addr = m1_addr; e_wdata = m1_wdata; end
      else if (x0) begin e_addr = m0_addr; e_wdata = m0_wdata; end
      if (x0 || x1)
        $display("gnt port%0d %s addr 0x%0h cycle %0d", x1, e_w ? "wr" : "rd", e_addr, cycle);
      if (e_r) sb.push_back('{x1, ref_mem[e_addr[7:0]], cycle + 2});
      if (e_w) ref_mem[e_addr[7:0]] = e_wdata;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle(input int n);
    m0_req = 1'b0;
    m1_req = 1'b0;
    repeat (n) step();
  endtask

  int n0, n1, nact;

  initial begin
    // Reset with both requests up: grants must stay low
    set0(1'b1, 1'b0, 32'h10, '0);
    set1(1'b1, 1'b0, 32'h20, '0);
    repeat (2) step();
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_mem_r", mem_r, 1'b0);
    check("rst_mem_w", mem_w, 1'b0);
    check("rst_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    idle(0);
    rst_n = 1'b1;
    step();

    // 1: m0 write then read back
    set0(1'b1, 1'b1, 32'h10, 32'hDEADBEEF);
    @(negedge clk) check("t1_wr_gnt", m0_gnt, 1'b1);
    step();
    set0(1'b1, 1'b0, 32'h10, '0);
    @(negedge clk) check("t1_rd_gnt", m0_gnt, 1'b1);
    step();
    idle(4);

    // 3: m1 preloads 0x20..0x22 then reads them back-to-back
    for (int i = 0; i < 3; i++) begin
      set1(1'b1, 1'b1, 32'h20 + i, i + 1);
      @(negedge clk) check("t3_wr_gnt", m1_gnt, 1'b1);
      step();
    end
    for (int i = 0; i < 3; i++) begin
      set1(1'b1, 1'b0, 32'h20 + i, '0);
      @(negedge clk) check("t3_rd_gnt", m1_gnt, 1'b1);
      step();
    end
    idle(4);

    // 2: both ports contend continuously
    set0(1'b1, 1'b0, 32'h10, '0);
    set1(1'b1, 1'b0, 32'h21, '0);
    n0 = 0; n1 = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n0 += int'(m0_gnt);
      n1 += int'(m1_gnt);
      step();
    end
`ifdef DMEM_ARB_RR_EN
    check("t2_m0_count", n0, 5);
    check("t2_m1_count", n1, 5);
`else
    check("t2_m0_count", n0, 8);
    check("t2_m1_count", n1, 2);
`endif
    idle(4);

    // 4: m1 write followed by m0 read of the same word
    set1(1'b1, 1'b1, 32'h30, 32'h55);
    @(negedge clk) check("t4_wr_gnt", m1_gnt, 1'b1);
    step();
    m1_req = 1'b0;
    set0(1'b1, 1'b0, 32'h30, '0);
    @(negedge clk) check("t4_rd_gnt", m0_gnt, 1'b1);
    step();
    idle(4);

    // 5: contention leaves port 1 owed a turn, then reset clears it
    set0(1'b1, 1'b0, 32'h10, '0);
    set1(1'b1, 1'b0, 32'h22, '0);
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    check("t5_mem_r", mem_r, 1'b0);
    check("t5_mem_w", mem_w, 1'b0);
    check("t5_mem_addr", mem_addr, '0);
    check("t5_mem_wdata", mem_wdata, '0);
    check("t5_gnt", {m0_gnt, m1_gnt}, 2'b00);
    check("t5_rvalid", {m0_rvalid, m1_rvalid}, 2'b00);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_tie_m0", {m0_gnt, m1_gnt}, 2'b10);
    nact = int'(m0_rvalid) + int'(m1_rvalid);
    step();
    idle(0);
    @(negedge clk);
    nact += int'(m0_rvalid) + int'(m1_rvalid);
    check("t5_no_stale_rvalid", nact, 0);
    step();
    idle(4);

    // 6: ten idle cycles
    nact = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      nact += int'(mem_r) + int'(mem_w) + int'(m0_gnt) + int'(m1_gnt) + int'(m0_rvalid) + int'(m1_rvalid);
      step();
    end
    check("t6_idle_activity", nact, 0);

    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
